// File: rtl/div_iterative_unit.sv
// ============================================================================
// div_iterative_unit
//
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per CALC cycle by shifting the
// remainder:quotient pair left and trial-subtracting the divisor magnitude.
// A FIXUP cycle applies operand signs and the RISC-V special-case values.
// The result is then held in DONE until the consumer takes it.
//
// Optional build macro: DIV_EARLY_OUT_EN
//   defined   - divide-by-zero and signed overflow are resolved at the accept
//               edge, which goes straight to DONE with the special result.
//   undefined - special cases run through CALC and FIXUP like any other
//               operation, and the special value is forced at FIXUP.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   flush      in   drop any in-flight or held operation
//   in_valid   in   operation request
//   in_ready   out  high only in IDLE
//   op         in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend   in   rs1 value
//   divisor    in   rs2 value
//   out_valid  out  high only in DONE
//   out_ready  in   consumer takes result
//   result     out  quotient (DIV/DIVU) or remainder (REM/REMU)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// CALC  | one restoring-division iteration per cycle, XLEN cycles
// FIXUP | apply signs / special cases, register the result
// DONE  | result held, out_valid high until out_ready
// ============================================================================
module div_iterative_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            dvd_neg_q, dvd_neg_d;
    logic            dvs_neg_q, dvs_neg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Decode of the request as presented on the inputs (used at accept only).
    logic            in_signed;
    logic            in_dvd_neg;
    logic            in_dvs_neg;
    logic            in_div0;
    logic            in_ovf;

    assign in_signed  = ~op[0];
    assign in_dvd_neg = in_signed & dividend[XLEN-1];
    assign in_dvs_neg = in_signed & divisor[XLEN-1];
    assign in_div0    = (divisor == '0);
    assign in_ovf     = in_signed && (dividend == INT_MIN) && (divisor == '1);

    // Shift remainder:quotient left by one and trial-subtract at XLEN+1 bits.
    // The remainder is always smaller than the divisor, so the shifted value
    // fits in XLEN+1 bits and the top bit of the difference is its sign.
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_shift;

    assign rem_shift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

    // Sign-corrected results from the magnitudes.
    logic [XLEN-1:0] fix_quo;
    logic [XLEN-1:0] fix_rem;
    logic [XLEN-1:0] fix_res;

    assign fix_quo = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
    assign fix_rem = dvd_neg_q ? -rem_q : rem_q;

    always_comb begin
        fix_res = op_q[1] ? fix_rem : fix_quo;
        // Divide-by-zero leaves the magnitude of the dividend in the
        // remainder, so only the quotient needs forcing to all ones.
        if (div0_q) begin
            fix_res = op_q[1] ? fix_rem : '1;
        end else if (ovf_q) begin
            fix_res = op_q[1] ? '0 : INT_MIN;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d      = op;
                    dvd_neg_d = in_dvd_neg;
                    dvs_neg_d = in_dvs_neg;
                    div0_d    = in_div0;
                    ovf_d     = in_ovf;
                    quo_d     = in_dvd_neg ? -dividend : dividend;
                    dvs_d     = in_dvs_neg ? -divisor : divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (in_div0) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = S_DONE;
                    end else if (in_ovf) begin
                        result_d = op[1] ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end
`endif
                end
            end

            S_CALC: begin
                rem_d = trial[XLEN] ? rem_shift : trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIXUP;
                end
            end

            S_FIXUP: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_div_iterative_unit.sv
// Bench for div_iterative_unit: directed cases plus randomized operations
// checked against an arithmetic reference of the RV32M division rules.
module tb_div_iterative_unit;

    localparam int LAT_NORMAL = 33;
`ifdef DIV_EARLY_OUT_EN
    // Special cases reach DONE at the accept edge: out_valid is already
    // high in the cycle right after it.
    localparam int LAT_SPECIAL = 0;
`else
    localparam int LAT_SPECIAL = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    div_iterative_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'($urandom);
        dividend = $urandom;
        divisor = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        accept(o, a, b);
        wait_valid(lat);
        check($sformatf("%s result op=%0d a=%h b=%h", tag, o, a, b), result, ref_div(o, a, b));
        check($sformatf("%s latency", tag), lat, is_special(o, a, b) ? LAT_SPECIAL : LAT_NORMAL);
        take_result();
    endtask

    initial begin
        int lat;
        int seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run(2'b01, 32'd100, 32'd7, "divu_100_7");
        run(2'b11, 32'd100, 32'd7, "remu_100_7");
        run(2'b00, 32'hFFFF_FF9C, 32'd7, "div_m100_7");
        run(2'b10, 32'hFFFF_FF9C, 32'd7, "rem_m100_7");
        run(2'b10, 32'd100, 32'hFFFF_FFF9, "rem_100_m7");
        run(2'b00, 32'd5, 32'd0, "div_by_zero");
        run(2'b11, 32'd5, 32'd0, "remu_by_zero");
        run(2'b10, 32'hFFFF_FFFB, 32'd0, "rem_neg_by_zero");
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_overflow");

        // Backpressure, then a back-to-back operation
        accept(2'b01, 32'd100, 32'd7);
        wait_valid(lat);
        check("bp_result", result, 32'd14);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_result", result, 32'd14);
            check("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        take_result();
        run(2'b01, 32'hFFFF_FFFF, 32'd1, "back_to_back");

        // Flush during CALC (sampled at the 10th edge after accept)
        accept(2'b01, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("flush_no_out_valid", seen, 32'd0);
        run(2'b01, 32'd9, 32'd3, "after_flush");

        // Flush together with a request in IDLE drops the request
        op = 2'b01; dividend = 32'd50; divisor = 32'd5;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_drop_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("flush_drop_no_out_valid", seen, 32'd0);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'd0;
                3:       rb = -$urandom_range(1, 15);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            run(ro, ra, rb, $sformatf("rand%0d", i));
        end

        // Reset while holding a result in DONE
        accept(2'b01, 32'd100, 32'd7);
        wait_valid(lat);
        check("rst_done_result_before", result, 32'd14);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done_result", result, 32'd0);
        check("rst_done_in_ready", {31'd0, in_ready}, 32'd1);
        run(2'b11, 32'd100, 32'd7, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
